router_pkt_loader: RTL

//  Input stage of the 1x3 router, directly upstream of the three router_fifo instances.

---
 rtl/router_pkt_loader_if.sv | 26 ++
 rtl/router_pkt_loader.sv | 131 +++++++++++++
 2 files changed

// File: rtl/router_pkt_loader_if.sv
// Byte-serial link between the packet source, the loader and the three router FIFOs.
// The loader takes the slave side; the source/FIFO side (or a bench) takes master.
interface router_pkt_loader_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_DEST = 3
);
    logic                pkt_valid;
    logic [DATA_W-1:0]   data_in;
    logic [NUM_DEST-1:0] fifo_full;
    logic                busy;
    logic [NUM_DEST-1:0] write_enb;
    logic [DATA_W-1:0]   data_out;
    logic                lfd_state;
    logic                parity_done;
    logic                err;

    modport master (
        output pkt_valid, data_in, fifo_full,
        input  busy, write_enb, data_out, lfd_state, parity_done, err
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        output busy, write_enb, data_out, lfd_state, parity_done, err
    );
endinterface

// File: rtl/router_pkt_loader.sv
// Router input stage: steers header+payload bytes into the addressed FIFO through a
// one-byte hold register, stalls the source on FIFO full, and checks the parity byte.
module router_pkt_loader #(
    parameter int DATA_W   = 8,
    parameter int NUM_DEST = 3
) (
    input logic                clk,
    input logic                rst,
    router_pkt_loader_if.slave bus
);
    localparam int ADDR_W = 2;
    localparam int CNT_W  = DATA_W - 2;

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PARITY, DROP} state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   hold_q;
    logic                hold_vld_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   par_q;
    logic                parity_done_q;
    logic                err_q;

    logic                full_sel;
    logic                wr_go;
    logic                busy;
    logic                lfd;
    logic                accept;
    logic [NUM_DEST-1:0] wr_en;

    // Write and stall decisions react to fifo_full in the same cycle.
    always_comb begin
        full_sel = 1'b0;
        for (int k = 0; k < NUM_DEST; k++) begin
            if (addr_q == ADDR_W'(k)) full_sel = bus.fifo_full[k];
        end
        wr_go = 1'b0;
        busy  = 1'b0;
        lfd   = 1'b0;
        case (state_q)
            HDR: begin
                busy  = 1'b1;
                wr_go = !full_sel;
                lfd   = !full_sel;
            end
            PAYLOAD: begin
                wr_go = hold_vld_q && !full_sel;
                busy  = (hold_vld_q && full_sel) || (cnt_q == '0);
            end
            default: ;
        endcase
        accept = bus.pkt_valid && !busy;
        wr_en  = '0;
        for (int k = 0; k < NUM_DEST; k++) begin
            wr_en[k] = wr_go && (addr_q == ADDR_W'(k));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            hold_vld_q    <= 1'b0;
            addr_q        <= '0;
            cnt_q         <= '0;
            par_q         <= '0;
            parity_done_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            parity_done_q <= 1'b0;
            err_q         <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        hold_q     <= bus.data_in;
                        par_q      <= bus.data_in;
                        cnt_q      <= bus.data_in[DATA_W-1:2];
                        addr_q     <= bus.data_in[ADDR_W-1:0];
                        hold_vld_q <= 1'b0;
                        state_q    <= (int'(bus.data_in[ADDR_W-1:0]) < NUM_DEST) ? HDR : DROP;
                    end
                end
                HDR: begin
                    if (wr_go) begin
                        hold_vld_q <= 1'b0;
                        state_q    <= (cnt_q == '0) ? PARITY : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    // A write and a new accept may coincide: the held byte leaves as the next one lands.
                    if (accept) begin
                        hold_q     <= bus.data_in;
                        hold_vld_q <= 1'b1;
                        par_q      <= par_q ^ bus.data_in;
                        cnt_q      <= cnt_q - CNT_W'(1);
                    end else if (wr_go) begin
                        hold_vld_q <= 1'b0;
                    end
                    if ((cnt_q == '0) && (!hold_vld_q || wr_go)) state_q <= PARITY;
                end
                PARITY: begin
                    if (accept) begin
                        parity_done_q <= 1'b1;
                        err_q         <= (bus.data_in != par_q);
                        state_q       <= IDLE;
                    end
                end
                DROP: begin
                    if (accept) begin
                        if (cnt_q == '0) begin
                            parity_done_q <= 1'b1;
                            err_q         <= 1'b1;
                            state_q       <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.write_enb   = wr_en;
    assign bus.data_out    = hold_q;
    assign bus.lfd_state   = lfd;
    assign bus.parity_done = parity_done_q;
    assign bus.err         = err_q;
endmodule
